jpeg_block_pingpong_buffer: RTL and testbench

- Two-bank (ping-pong) block buffer between the pixel/level-shift front end and the DCT stage of the JPEG encoder.
- Accepts a block either serially, one sample per valid/ready beat, or as one parallel packed load.
- Presents each completed block as a packed bus with a valid/ready handshake, so the next block can fill while the DCT consumes the current one.
- Successor to the single-bank 64x12 buffer: parametrised width/depth, double buffering, backpressure, flush.

---
 rtl/jpeg_block_pingpong_buffer_if.sv | 50 +++++
 rtl/jpeg_block_pingpong_buffer.sv | 168 ++++++++++++++++
 tb/tb_jpeg_block_pingpong_buffer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_block_pingpong_buffer_if.sv
// Handshake bundle for jpeg_block_pingpong_buffer.
//   wr_*   : serial sample stream, one sample per valid/ready beat
//   load_* : parallel packed block load, one block per valid/ready beat
//   out_*  : packed block presentation towards the DCT stage
// Modports:
//   slave  : the buffer itself (sinks wr/load, sources out)
//   master : the surrounding producer/consumer side
// Packed blocks carry sample k at bits [k*DATA_WIDTH +: DATA_WIDTH].
interface jpeg_block_pingpong_buffer_if #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned DEPTH      = 64
);

   logic                          wr_valid;
   logic                          wr_ready;
   logic [DATA_WIDTH-1:0]         wr_data;

   logic                          load_valid;
   logic                          load_ready;
   logic [DATA_WIDTH*DEPTH-1:0]   load_data;

   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_WIDTH*DEPTH-1:0]   out_data;

   modport slave (
      input  wr_valid,
      output wr_ready,
      input  wr_data,
      input  load_valid,
      output load_ready,
      input  load_data,
      output out_valid,
      input  out_ready,
      output out_data
   );

   modport master (
      output wr_valid,
      input  wr_ready,
      output wr_data,
      output load_valid,
      input  load_ready,
      output load_data,
      input  out_valid,
      output out_ready,
      input  out_data
   );

endinterface

// File: rtl/jpeg_block_pingpong_buffer.sv
// Two-bank (ping-pong) block buffer between the level-shift front end and the DCT.
// One bank fills (serially or by a single parallel load) while the other is
// presented to the consumer as a packed block.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset; clears storage and all pointers
//   flush        discard a partially filled serial block (wins over a serial beat)
//   wr_transpose column-major serial addressing (only with JPEG_BUF_TRANSPOSE_EN)
//   bus          handshake bundle (slave modport): wr_*, load_*, out_*
//   wr_index     next serial write position
//   blocks_full  number of full banks, 0..2
//
// Optional feature macro: JPEG_BUF_TRANSPOSE_EN
//   When defined, the wr_transpose port exists and serial beats with
//   wr_transpose=1 are stored at (idx % BLOCK_W)*BLOCK_W + idx/BLOCK_W.
//   Parallel loads are never transposed.
module jpeg_block_pingpong_buffer #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned BLOCK_W    = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       flush,
`ifdef JPEG_BUF_TRANSPOSE_EN
   input  logic                       wr_transpose,
`endif
   jpeg_block_pingpong_buffer_if.slave bus,
   output logic [$clog2(DEPTH)-1:0]   wr_index,
   output logic [1:0]                 blocks_full
);

   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

   // Elaboration-time parameter sanity checks.
   if (DEPTH < 4 || (1 << IdxW) != DEPTH) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 4");
   end
   if (BLOCK_W < 2) begin : g_bad_block_w
      $error("BLOCK_W must be at least 2");
   end
`ifdef JPEG_BUF_TRANSPOSE_EN
   if (BLOCK_W * BLOCK_W != DEPTH) begin : g_bad_square
      $error("DEPTH must equal BLOCK_W*BLOCK_W for transposed addressing");
   end
`endif

   typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] bank_t;

   bank_t           bank0_q, bank0_d;
   bank_t           bank1_q, bank1_d;
   logic [1:0]      bank_full_q, bank_full_d;
   logic            wbank_q, wbank_d;
   logic            rbank_q, rbank_d;
   logic [IdxW-1:0] wr_index_q, wr_index_d;
   logic [IdxW-1:0] wr_addr;

   logic            wbank_free;
   logic            load_fire;
   logic            wr_fire;
   logic            out_fire;
   logic            fill_done;

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   assign wbank_free     = !bank_full_q[wbank_q];
   // Parallel load has priority: serial beats stall while load_valid is high.
   assign bus.wr_ready   = wbank_free & !bus.load_valid;
   // A parallel load may only start on a bank with no partial serial fill.
   assign bus.load_ready = wbank_free & (wr_index_q == '0);

   assign load_fire = bus.load_valid & bus.load_ready;
   // A flushed beat is dropped even though wr_ready was presented.
   assign wr_fire   = bus.wr_valid & bus.wr_ready & !flush;
   assign out_fire  = bus.out_valid & bus.out_ready;
   assign fill_done = load_fire | (wr_fire & (wr_index_q == LastIdx));

   // ---------------------------------------------------------------------------
   // Serial write address
   // ---------------------------------------------------------------------------
`ifdef JPEG_BUF_TRANSPOSE_EN
   always_comb begin
      wr_addr = wr_index_q;
      if (wr_transpose) begin
         wr_addr = IdxW'((32'(wr_index_q) % BLOCK_W) * BLOCK_W + 32'(wr_index_q) / BLOCK_W);
      end
   end
`else
   assign wr_addr = wr_index_q;
`endif

   // ---------------------------------------------------------------------------
   // Bank storage next state
   // ---------------------------------------------------------------------------
   always_comb begin
      bank0_d = bank0_q;
      bank1_d = bank1_q;
      if (load_fire) begin
         if (wbank_q) begin
            bank1_d = bus.load_data;
         end else begin
            bank0_d = bus.load_data;
         end
      end else if (wr_fire) begin
         if (wbank_q) begin
            bank1_d[wr_addr] = bus.wr_data;
         end else begin
            bank0_d[wr_addr] = bus.wr_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, full flags and serial index next state
   // ---------------------------------------------------------------------------
   always_comb begin
      bank_full_d = bank_full_q;
      // Release and fill always hit different banks: a fill needs the write
      // bank empty, a release needs the read bank full.
      if (out_fire) begin
         bank_full_d[rbank_q] = 1'b0;
      end
      if (fill_done) begin
         bank_full_d[wbank_q] = 1'b1;
      end

      wbank_d = wbank_q ^ fill_done;
      rbank_d = rbank_q ^ out_fire;

      wr_index_d = wr_index_q;
      if (flush) begin
         wr_index_d = '0;
      end else if (wr_fire) begin
         // DEPTH is a power of two, so the increment wraps to 0 after the last beat.
         wr_index_d = wr_index_q + IdxW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bank0_q     <= '0;
         bank1_q     <= '0;
         bank_full_q <= '0;
         wbank_q     <= 1'b0;
         rbank_q     <= 1'b0;
         wr_index_q  <= '0;
      end else begin
         bank0_q     <= bank0_d;
         bank1_q     <= bank1_d;
         bank_full_q <= bank_full_d;
         wbank_q     <= wbank_d;
         rbank_q     <= rbank_d;
         wr_index_q  <= wr_index_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.out_valid = bank_full_q[rbank_q];
   assign bus.out_data  = rbank_q ? bank1_q : bank0_q;
   assign wr_index      = wr_index_q;
   assign blocks_full   = {1'b0, bank_full_q[0]} + {1'b0, bank_full_q[1]};

endmodule

// File: tb/tb_jpeg_block_pingpong_buffer.sv
// Directed self-checking bench for jpeg_block_pingpong_buffer.
module tb_jpeg_block_pingpong_buffer;

   localparam int unsigned DW  = 12;
   localparam int unsigned DEP = 64;

   logic       clock;
   logic       reset_n;
   logic       flush;
   logic       wr_transpose;
   logic [5:0] wr_index;
   logic [1:0] blocks_full;

   int tests;
   int fails;

   jpeg_block_pingpong_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

   jpeg_block_pingpong_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEP),
      .BLOCK_W    (8)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .flush        (flush),
`ifdef JPEG_BUF_TRANSPOSE_EN
      .wr_transpose (wr_transpose),
`endif
      .bus          (bus.slave),
      .wr_index     (wr_index),
      .blocks_full  (blocks_full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] slice(input int k);
      return 32'(bus.out_data[k*DW +: DW]);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Serial beats data = base+k for k in [first, first+count); assumes no stall.
   task automatic beats(input int base, input int first, input int count);
      for (int k = first; k < first + count; k++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 12'(base + k);
         tick();
      end
      bus.wr_valid = 1'b0;
   endtask

   int errs;
   int k_acc;
   int stalls;
   int hs;
   logic [31:0] hs_slice3 [8];

   initial begin
      tests          = 0;
      fails          = 0;
      reset_n        = 1'b0;
      flush          = 1'b0;
      wr_transpose   = 1'b0;
      bus.wr_valid   = 1'b0;
      bus.wr_data    = '0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.out_ready  = 1'b0;

      // Reset state
      repeat (2) tick();
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_blocks_full", 32'(blocks_full), 0);
      check("rst_wr_index", 32'(wr_index), 0);
      check("rst_out_data_zero", 32'(|bus.out_data), 0);
      check("rst_wr_ready", 32'(bus.wr_ready), 1);
      check("rst_load_ready", 32'(bus.load_ready), 1);
      reset_n = 1'b1;
      tick();

      // Single serial block, data = k
      beats(0, 0, 63);
      check("blk0_pre_last_idx", 32'(wr_index), 63);
      check("blk0_pre_last_valid", 32'(bus.out_valid), 0);
      beats(0, 63, 1);
      check("blk0_out_valid", 32'(bus.out_valid), 1);
      check("blk0_blocks_full", 32'(blocks_full), 1);
      check("blk0_wr_index", 32'(wr_index), 0);
      errs = 0;
      for (int i = 0; i < 64; i++) if (slice(i) !== 32'(i)) errs++;
      check("blk0_all_slices", 32'(errs), 0);

      // Second block fills the other bank; both full
      beats(100, 0, 64);
      check("full_blocks_full", 32'(blocks_full), 2);
      check("full_wr_ready", 32'(bus.wr_ready), 0);
      check("full_load_ready", 32'(bus.load_ready), 0);
      // A held beat must not overwrite anything while full
      bus.wr_valid = 1'b1;
      bus.wr_data  = 12'hFFF;
      tick();
      bus.wr_valid = 1'b0;
      check("full_hold_wr_index", 32'(wr_index), 0);
      check("full_first_slice5", slice(5), 5);
      bus.out_ready = 1'b1;
      tick();
      check("drain1_slice5", slice(5), 105);
      check("drain1_out_valid", 32'(bus.out_valid), 1);
      check("drain1_blocks_full", 32'(blocks_full), 1);
      tick();
      bus.out_ready = 1'b0;
      check("drain2_out_valid", 32'(bus.out_valid), 0);
      check("drain2_blocks_full", 32'(blocks_full), 0);

      // Partial block then flush together with a beat
      beats(200, 0, 10);
      check("pre_flush_idx", 32'(wr_index), 10);
      check("pre_flush_load_ready", 32'(bus.load_ready), 0);
      bus.wr_valid = 1'b1;
      bus.wr_data  = 12'h777;
      flush        = 1'b1;
      tick();
      bus.wr_valid = 1'b0;
      flush        = 1'b0;
      check("flush_wr_index", 32'(wr_index), 0);
      check("flush_load_ready", 32'(bus.load_ready), 1);
      check("flush_blocks_full", 32'(blocks_full), 0);
      bus.load_valid = 1'b1;
      bus.load_data  = {64{12'hABC}};
      tick();
      bus.load_valid = 1'b0;
      check("load_out_valid", 32'(bus.out_valid), 1);
      check("load_wr_index", 32'(wr_index), 0);
      errs = 0;
      for (int i = 0; i < 64; i++) if (slice(i) !== 32'h0ABC) errs++;
      check("load_all_abc", 32'(errs), 0);

      // Load and serial beat together with one bank free: load wins
      bus.load_valid = 1'b1;
      bus.load_data  = {64{12'h123}};
      bus.wr_valid   = 1'b1;
      bus.wr_data    = 12'h007;
      #1;
      check("prio_wr_ready", 32'(bus.wr_ready), 0);
      check("prio_load_ready", 32'(bus.load_ready), 1);
      tick();
      bus.load_valid = 1'b0;
      bus.wr_valid   = 1'b0;
      check("prio_blocks_full", 32'(blocks_full), 2);
      check("prio_wr_index", 32'(wr_index), 0);
      bus.out_ready = 1'b1;
      #1;
      check("prio_first_out", slice(0), 32'h0ABC);
      tick();
      check("prio_second_out", slice(0), 32'h0123);
      tick();
      bus.out_ready = 1'b0;
      check("prio_drained", 32'(blocks_full), 0);

      // Continuous stream of 256 beats with the consumer always ready
      k_acc  = 0;
      stalls = 0;
      hs     = 0;
      bus.out_ready = 1'b1;
      bus.wr_valid  = 1'b1;
      for (int c = 0; c < 400 && k_acc < 256; c++) begin
         logic acc;
         bus.wr_data = 12'(k_acc);
         #1;
         acc = bus.wr_valid & bus.wr_ready;
         if (!bus.wr_ready && k_acc >= 64) stalls++;
         if (bus.out_valid && bus.out_ready) begin
            if (hs < 8) hs_slice3[hs] = slice(3);
            hs++;
         end
         tick();
         if (acc) k_acc++;
      end
      bus.wr_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (bus.out_valid && bus.out_ready) begin
            if (hs < 8) hs_slice3[hs] = slice(3);
            hs++;
         end
         tick();
      end
      bus.out_ready = 1'b0;
      check("stream_beats", 32'(k_acc), 256);
      check("stream_stalls", 32'(stalls), 0);
      check("stream_handshakes", 32'(hs), 4);
      check("stream_blk3_slice3", hs_slice3[3], 195);
      check("stream_blocks_full", 32'(blocks_full), 0);

`ifdef JPEG_BUF_TRANSPOSE_EN
      // Column-major serial addressing
      wr_transpose = 1'b1;
      beats(0, 0, 64);
      wr_transpose = 1'b0;
      check("tr_slice0", slice(0), 0);
      check("tr_slice1", slice(1), 8);
      check("tr_slice8", slice(8), 1);
      check("tr_slice63", slice(63), 63);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
`endif

      // Reset mid-block
      beats(1, 0, 64);
      beats(500, 0, 30);
      check("mid_wr_index", 32'(wr_index), 30);
      check("mid_out_valid", 32'(bus.out_valid), 1);
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 0);
      check("arst_wr_index", 32'(wr_index), 0);
      check("arst_out_data_zero", 32'(|bus.out_data), 0);
      check("arst_blocks_full", 32'(blocks_full), 0);
      tick();
      reset_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
